// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera SCCB configuration sequencer:
//   sccb_state_t   sequencer state encoding
//   CAM_TABLE_END  table terminator entry
//   CAM_SOFT_RST   sensor soft-reset write {reg, val}
//   CAM_TABLE      default register table, terminator included
//   cam_rom()      constant lookup into CAM_TABLE
// Build option: CAM_SOFT_RESET_EN adds the WAIT state used after the
// sensor soft-reset write.
// -----------------------------------------------------------------------------
package cam_pkg;

`ifdef CAM_SOFT_RESET_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BYTE  = 3'd3,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6,
    ST_WAIT  = 3'd7
  } sccb_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BYTE  = 3'd3,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } sccb_state_t;
`endif

  localparam logic [15:0] CAM_TABLE_END = 16'hFFFF;
  localparam logic [15:0] CAM_SOFT_RST  = 16'h1280;

  // Entry format {reg[15:8], val[7:0]}; the terminator must be present.
  localparam int unsigned CAM_TABLE_LEN = 3;
  localparam logic [15:0] CAM_TABLE [CAM_TABLE_LEN] = '{
    16'h1204,
    16'h40D0,
    CAM_TABLE_END
  };

  // Addresses past the end of the table read as the terminator, so a run can
  // never walk off the ROM even if the terminator were missing.
  function automatic logic [15:0] cam_rom(input logic [7:0] idx);
    logic [15:0] e;
    e = CAM_TABLE_END;
    for (int i = 0; i < int'(CAM_TABLE_LEN); i++) begin
      if (idx == 8'(i)) e = CAM_TABLE[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/sccb_tick.sv
// -----------------------------------------------------------------------------
// sccb_tick
// Quarter-bit strobe generator for the SCCB sequencer. A down-counter reloads
// with QDIV-1 and fires tick_o for one clock each time it reaches zero, so the
// strobe period is QDIV clocks. While clr_i is high the counter is held at its
// reload value and no tick is produced, which makes the first tick after clr_i
// drops land exactly QDIV clocks later.
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   clr_i    hold/restart the counter (sequencer not bit-timing)
//   tick_o   one-clock quarter-phase strobe
// -----------------------------------------------------------------------------
module sccb_tick #(
  parameter int unsigned QDIV = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic tick_o
);

  if (QDIV < 1) begin : g_qdiv_check
    $error("sccb_tick: QDIV must be at least 1 (CLK_FREQ_HZ too low for SCCB_FREQ_HZ)");
  end

  localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(QDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == '0)) cnt_d = RELOAD;
    else                        cnt_d = cnt_q - CW'(1);
  end

  assign tick_o = !clr_i && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cam_sccb_init.sv
// -----------------------------------------------------------------------------
// cam_sccb_init
// Walks the sensor register table and writes each entry over SCCB as a
// 3-phase write {DEV_ADDR, reg, val}. When the terminator is reached it raises
// done/capture_en, releasing the pixel FIFO.
// Parameters:
//   CLK_FREQ_HZ, SCCB_FREQ_HZ  quarter-bit period QDIV = CLK/(4*SCCB) clocks
//   DEV_ADDR                   sensor 8-bit write address
//   AUTO_START                 begin a run on the first cycle after reset
//   TABLE_LEN                  number of ROM entries visible (rest = terminator)
// Ports:
//   clk, reset (async, active-low), start (run request pulse)
//   sioc, siod_o, siod_oe      SCCB bus (siod_oe=0 releases SIOD)
//   busy, done, capture_en     run status; capture_en mirrors done
//   index                      current table entry
// Build option: CAM_SOFT_RESET_EN prepends a sensor soft-reset write
// (0x12=0x80) and a 1 ms WAIT before entry 0.
//
// state | meaning
// IDLE  | bus idle, waiting for start (or auto start after reset)
// LOAD  | read table[index]; terminator ends the run
// START | start condition, 4 quarters
// BYTE  | 27 bits (3 bytes x 8 data + 1 released ACK slot)
// STOP  | stop condition, 4 quarters
// GAP   | 4 idle quarters between transactions
// DONE  | table written, capture enabled, waiting for a new start
// WAIT  | post soft-reset settle time (CAM_SOFT_RESET_EN only)
// -----------------------------------------------------------------------------
module cam_sccb_init
  import cam_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter bit          AUTO_START   = 1'b1,
  parameter int unsigned TABLE_LEN    = CAM_TABLE_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_oe,
  output logic       busy,
  output logic       done,
  output logic       capture_en,
  output logic [7:0] index
);

  localparam int unsigned QDIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);

`ifdef CAM_SOFT_RESET_EN
  localparam int unsigned WAIT_CLKS = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
`endif

  sccb_state_t state_q, state_d;
  logic [1:0]  q_q, q_d;          // quarter phase q0..q3
  logic [3:0]  bit_q, bit_d;      // bit within byte, 8 = ACK slot
  logic [1:0]  byte_q, byte_d;    // byte within transaction
  logic [23:0] sr_q, sr_d;        // {DEV_ADDR, reg, val}, MSB first
  logic [7:0]  index_q, index_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        first_q;
  logic        sioc_q, sioc_d;
  logic        siod_q, siod_d;
  logic        oe_q, oe_d;
`ifdef CAM_SOFT_RESET_EN
  logic        soft_q, soft_d;    // soft-reset write still pending/in flight
  logic [31:0] wcnt_q, wcnt_d;
`endif

  logic        tick;
  logic        tick_clr;
  logic [15:0] entry;

  // Only the bus phases are quarter-timed; everything else holds the divider.
`ifdef CAM_SOFT_RESET_EN
  assign tick_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                    (state_q == ST_DONE) || (state_q == ST_WAIT);
`else
  assign tick_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                    (state_q == ST_DONE);
`endif

  sccb_tick #(
    .QDIV (QDIV)
  ) u_tick (
    .clk_i   (clk),
    .rst_n_i (reset),
    .clr_i   (tick_clr),
    .tick_o  (tick)
  );

  always_comb begin
    entry = CAM_TABLE_END;
    if (32'(index_q) < TABLE_LEN) entry = cam_rom(index_q);
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sr_d    = sr_q;
    index_d = index_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef CAM_SOFT_RESET_EN
    soft_d  = soft_q;
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start || (first_q && AUTO_START)) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
          index_d = '0;
`ifdef CAM_SOFT_RESET_EN
          soft_d  = 1'b1;
`endif
        end
      end
      ST_LOAD: begin
        q_d = 2'd0;
`ifdef CAM_SOFT_RESET_EN
        if (soft_q) begin
          sr_d    = {DEV_ADDR, CAM_SOFT_RST};
          state_d = ST_START;
        end else
`endif
        if (entry == CAM_TABLE_END) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          sr_d    = {DEV_ADDR, entry};
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) begin
            state_d = ST_BYTE;
            bit_d   = '0;
            byte_d  = '0;
          end
        end
      end
      ST_BYTE: begin
        if (tick) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) begin
            if (bit_q == 4'd8) begin
              bit_d = '0;
              if (byte_q == 2'd2) state_d = ST_STOP;
              else                byte_d  = byte_q + 2'd1;
            end else begin
              bit_d = bit_q + 4'd1;
              sr_d  = {sr_q[22:0], 1'b0};
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) begin
`ifdef CAM_SOFT_RESET_EN
            if (soft_q) begin
              soft_d  = 1'b0;
              wcnt_d  = 32'(WAIT_CLKS - 1);
              state_d = ST_WAIT;
            end else begin
              index_d = index_q + 8'd1;
              state_d = ST_LOAD;
            end
`else
            index_d = index_q + 8'd1;
            state_d = ST_LOAD;
`endif
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          index_d = '0;
`ifdef CAM_SOFT_RESET_EN
          soft_d  = 1'b1;
`endif
        end
      end
`ifdef CAM_SOFT_RESET_EN
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_LOAD;
        else              wcnt_d  = wcnt_q - 32'd1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus levels are derived from the next state so the registered outputs line
  // up with the state register instead of trailing it by a clock.
  always_comb begin
    sioc_d = 1'b1;
    siod_d = 1'b1;
    oe_d   = 1'b0;
    case (state_d)
      ST_START: begin
        oe_d   = 1'b1;
        siod_d = (q_d == 2'd0);
        sioc_d = (q_d != 2'd3);
      end
      ST_BYTE: begin
        sioc_d = (q_d == 2'd1) || (q_d == 2'd2);
        if (bit_d == 4'd8) begin
          oe_d   = 1'b0;
          siod_d = 1'b1;
        end else begin
          oe_d   = 1'b1;
          siod_d = sr_d[23];
        end
      end
      ST_STOP: begin
        oe_d   = 1'b1;
        sioc_d = (q_d != 2'd0);
        siod_d = (q_d >= 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sr_q    <= '0;
      index_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      first_q <= 1'b1;
      sioc_q  <= 1'b1;
      siod_q  <= 1'b1;
      oe_q    <= 1'b0;
`ifdef CAM_SOFT_RESET_EN
      soft_q  <= 1'b0;
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sr_q    <= sr_d;
      index_q <= index_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      first_q <= 1'b0;
      sioc_q  <= sioc_d;
      siod_q  <= siod_d;
      oe_q    <= oe_d;
`ifdef CAM_SOFT_RESET_EN
      soft_q  <= soft_d;
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign sioc       = sioc_q;
  assign siod_o     = siod_q;
  assign siod_oe    = oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign capture_en = done_q;
  assign index      = index_q;

endmodule

// File: tb/tb_cam_sccb_init.sv
// -----------------------------------------------------------------------------
// tb_cam_sccb_init
// Drives the sequencer with randomised start/reset timing and decodes the SCCB
// bus back into bytes, comparing against a reference built from the register
// table and the per-transaction timing (120 quarter ticks + 1 LOAD clock).
// A second instance with an empty table (TABLE_LEN=0) covers the terminator-only
// case.
// -----------------------------------------------------------------------------
module tb_cam_sccb_init;

  localparam int CLK_HZ     = 400_000;
  localparam int SCCB_HZ    = 100_000;
  localparam int QDIV       = CLK_HZ / (4 * SCCB_HZ);
  localparam int ENTRY_CLKS = 120 * QDIV + 1;
  localparam int WAIT_CLKS  = CLK_HZ / 1000;
  localparam int N_ENTRIES  = 2;
  localparam int EDGES_PER_TX = 56;  // 1 fall in START, 27 rise+fall pairs, 1 rise in STOP
`ifdef CAM_SOFT_RESET_EN
  localparam int SOFT = 1;
`else
  localparam int SOFT = 0;
`endif
  localparam int SOFT_CLKS = SOFT * (ENTRY_CLKS + WAIT_CLKS);
  localparam int DONE_EDGE = 2 + SOFT_CLKS + N_ENTRIES * ENTRY_CLKS;

  logic clk, reset, start;
  logic sioc, siod_o, siod_oe, busy, done, capture_en;
  logic [7:0] index;
  logic e_sioc, e_siod_o, e_siod_oe, e_busy, e_done, e_capture_en;
  logic [7:0] e_index;

  cam_sccb_init #(
    .CLK_FREQ_HZ (CLK_HZ), .SCCB_FREQ_HZ (SCCB_HZ), .DEV_ADDR (8'h42), .AUTO_START (1'b1)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .sioc (sioc), .siod_o (siod_o), .siod_oe (siod_oe),
    .busy (busy), .done (done), .capture_en (capture_en), .index (index)
  );

  cam_sccb_init #(
    .CLK_FREQ_HZ (CLK_HZ), .SCCB_FREQ_HZ (SCCB_HZ), .DEV_ADDR (8'h42), .AUTO_START (1'b1),
    .TABLE_LEN (0)
  ) dut_empty (
    .clk (clk), .reset (reset), .start (start),
    .sioc (e_sioc), .siod_o (e_siod_o), .siod_oe (e_siod_oe),
    .busy (e_busy), .done (e_done), .capture_en (e_capture_en), .index (e_index)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [15:0] tb_table [0:N_ENTRIES-1];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  got_bytes [$];
  int          start_cyc [$];
  int          stop_cyc [$];
  int          proto_err;
  int          sioc_edges;
  int          e_sioc_edges;
  bit          in_tx;
  int          nbits;
  logic [7:0]  shreg;
  logic        prev_sioc, prev_line, e_prev_sioc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus decoder: SIOD as seen on the wire (pull-up when released).
  task automatic mon_step();
    logic line;
    line = siod_oe ? siod_o : 1'b1;
    if (!reset) begin
      in_tx = 1'b0;
      nbits = 0;
      prev_sioc = sioc;
      prev_line = line;
      e_prev_sioc = e_sioc;
      return;
    end
    if (prev_sioc && sioc && (line !== prev_line)) begin
      if (!line) begin
        if (in_tx) proto_err++;
        in_tx = 1'b1;
        nbits = 0;
        shreg = '0;
        start_cyc.push_back(cyc);
      end else begin
        if (!in_tx || nbits != 27) proto_err++;
        in_tx = 1'b0;
        stop_cyc.push_back(cyc);
      end
    end else if ((line !== prev_line) && (prev_sioc || sioc)) begin
      proto_err++;
    end
    if (!prev_sioc && sioc) begin
      if (!in_tx) proto_err++;
      else if (nbits < 27) begin
        if ((nbits % 9) == 8) begin
          if (siod_oe) proto_err++;
        end else begin
          if (!siod_oe) proto_err++;
          shreg = {shreg[6:0], line};
        end
        nbits++;
        if ((nbits % 9) == 0) got_bytes.push_back(shreg);
      end
    end
    if (sioc !== prev_sioc) sioc_edges++;
    if (e_sioc !== e_prev_sioc) e_sioc_edges++;
    prev_sioc = sioc;
    prev_line = line;
    e_prev_sioc = e_sioc;
  endtask

  initial forever begin
    @(negedge clk);
    mon_step();
  end

  task automatic clear_mon();
    got_bytes.delete();
    start_cyc.delete();
    stop_cyc.delete();
    proto_err = 0;
    sioc_edges = 0;
    e_sioc_edges = 0;
  endtask

  task automatic build_exp();
    exp_bytes.delete();
    if (SOFT != 0) begin
      exp_bytes.push_back(8'h42);
      exp_bytes.push_back(8'h12);
      exp_bytes.push_back(8'h80);
    end
    for (int i = 0; i < N_ENTRIES; i++) begin
      exp_bytes.push_back(8'h42);
      exp_bytes.push_back(tb_table[i][15:8]);
      exp_bytes.push_back(tb_table[i][7:0]);
    end
  endtask

  function automatic int byte_diffs();
    int d;
    d = (got_bytes.size() > exp_bytes.size()) ? got_bytes.size() - exp_bytes.size()
                                              : exp_bytes.size() - got_bytes.size();
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
      if (got_bytes[i] !== exp_bytes[i]) d++;
    return d;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset(output int c0);
    @(negedge clk);
    reset = 1'b1;
    c0 = cyc;
    clear_mon();
  endtask

  task automatic wait_done(input bit use_empty, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((use_empty ? e_done : done) === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_start(output int p);
    start = 1'b1;
    p = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] got_v;
    apply_reset();
    got_v = {sioc, siod_o, siod_oe, busy, done, capture_en, index};
    n_total++;
    if (got_v !== 14'b11_0000_0000_0000) $display("FAIL reset_main: got %b expected %b", got_v, 14'b11_0000_0000_0000);
    else n_pass++;
    got_v = {e_sioc, e_siod_o, e_siod_oe, e_busy, e_done, e_capture_en, e_index};
    n_total++;
    if (got_v !== 14'b11_0000_0000_0000) $display("FAIL reset_empty: got %b expected %b", got_v, 14'b11_0000_0000_0000);
    else n_pass++;
  endtask

  task automatic test_auto_run();
    int c0, dcyc, d, gap, exp_gap;
    apply_reset();
    release_reset(c0);
    build_exp();
    @(negedge clk);
    n_total++;
    if ({busy, done} !== 2'b10) $display("FAIL auto_busy_rise: got busy/done %b expected 10", {busy, done});
    else n_pass++;
    wait_done(1'b0, dcyc);
    n_total++;
    if (dcyc - c0 !== DONE_EDGE) $display("FAIL auto_done_cycle: got %0d expected %0d", dcyc - c0, DONE_EDGE);
    else n_pass++;
    n_total++;
    if ({busy, capture_en} !== 2'b01) $display("FAIL auto_busy_fall: got busy/capture_en %b expected 01", {busy, capture_en});
    else n_pass++;
    n_total++;
    if (index !== 8'(N_ENTRIES)) $display("FAIL auto_index_end: got %0d expected %0d", index, N_ENTRIES);
    else n_pass++;
    d = byte_diffs();
    n_total++;
    if (d !== 0) $display("FAIL auto_bytes: got %0d bytes with %0d differences expected %0d bytes", got_bytes.size(), d, exp_bytes.size());
    else n_pass++;
    n_total++;
    if (proto_err !== 0) $display("FAIL auto_protocol: got %0d violations expected 0", proto_err);
    else n_pass++;
    n_total++;
    if (sioc_edges !== EDGES_PER_TX * (N_ENTRIES + SOFT)) $display("FAIL auto_sioc_edges: got %0d expected %0d", sioc_edges, EDGES_PER_TX * (N_ENTRIES + SOFT));
    else n_pass++;
    // stop (SIOD rise at STOP q2) to next start (SIOD fall at START q1)
    exp_gap = 7 * QDIV + 1 + SOFT * WAIT_CLKS;
    gap = (start_cyc.size() > 1 && stop_cyc.size() > 0) ? start_cyc[1] - stop_cyc[0] : -1;
    n_total++;
    if (gap !== exp_gap) $display("FAIL auto_tx_gap: got %0d expected %0d", gap, exp_gap);
    else n_pass++;
    repeat ($urandom_range(20, 60)) @(negedge clk);
    n_total++;
    if ({capture_en, done, sioc, siod_oe} !== 4'b1110) $display("FAIL auto_hold: got cap/done/sioc/oe %b expected 1110", {capture_en, done, sioc, siod_oe});
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int c0, dcyc, p, d;
    apply_reset();
    release_reset(c0);
    build_exp();
    repeat ($urandom_range(10, 230)) @(negedge clk);
    pulse_start(p);
    wait_done(1'b0, dcyc);
    n_total++;
    if (dcyc - c0 !== DONE_EDGE) $display("FAIL busy_start_cycle: got %0d expected %0d (pulse at %0d)", dcyc - c0, DONE_EDGE, p - c0);
    else n_pass++;
    d = byte_diffs();
    n_total++;
    if (d !== 0) $display("FAIL busy_start_bytes: got %0d bytes with %0d differences expected %0d bytes", got_bytes.size(), d, exp_bytes.size());
    else n_pass++;
  endtask

  task automatic test_restart();
    int dcyc, p, d;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    clear_mon();
    build_exp();
    @(negedge clk);
    pulse_start(p);
    n_total++;
    if ({done, capture_en, busy, index} !== {3'b001, 8'd0}) $display("FAIL restart_clear: got done/cap/busy/index %b expected %b", {done, capture_en, busy, index}, {3'b001, 8'd0});
    else n_pass++;
    wait_done(1'b0, dcyc);
    n_total++;
    if (dcyc - p !== DONE_EDGE - 1) $display("FAIL restart_done_cycle: got %0d expected %0d", dcyc - p, DONE_EDGE - 1);
    else n_pass++;
    d = byte_diffs();
    n_total++;
    if (d !== 0) $display("FAIL restart_bytes: got %0d bytes with %0d differences expected %0d bytes", got_bytes.size(), d, exp_bytes.size());
    else n_pass++;
    n_total++;
    if (proto_err !== 0) $display("FAIL restart_protocol: got %0d violations expected 0", proto_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int c0, dcyc, d;
    apply_reset();
    release_reset(c0);
    repeat ($urandom_range(20, 230)) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if ({sioc, siod_oe, busy, index} !== {3'b100, 8'd0}) $display("FAIL midreset_bus: got sioc/oe/busy/index %b expected %b", {sioc, siod_oe, busy, index}, {3'b100, 8'd0});
    else n_pass++;
    @(negedge clk);
    release_reset(c0);
    build_exp();
    @(negedge clk);
    n_total++;
    if ({busy, index} !== {1'b1, 8'd0}) $display("FAIL midreset_restart: got busy/index %b expected %b", {busy, index}, {1'b1, 8'd0});
    else n_pass++;
    wait_done(1'b0, dcyc);
    n_total++;
    if (dcyc - c0 !== DONE_EDGE) $display("FAIL midreset_done_cycle: got %0d expected %0d", dcyc - c0, DONE_EDGE);
    else n_pass++;
    d = byte_diffs();
    n_total++;
    if (d !== 0) $display("FAIL midreset_bytes: got %0d bytes with %0d differences expected %0d bytes", got_bytes.size(), d, exp_bytes.size());
    else n_pass++;
  endtask

  task automatic test_empty_table();
    int c0, dcyc;
    apply_reset();
    release_reset(c0);
    wait_done(1'b1, dcyc);
    n_total++;
    if (dcyc - c0 !== 2 + SOFT_CLKS) $display("FAIL empty_done_cycle: got %0d expected %0d", dcyc - c0, 2 + SOFT_CLKS);
    else n_pass++;
    n_total++;
    if (e_sioc_edges !== EDGES_PER_TX * SOFT) $display("FAIL empty_sioc_edges: got %0d expected %0d", e_sioc_edges, EDGES_PER_TX * SOFT);
    else n_pass++;
    n_total++;
    if ({e_busy, e_capture_en, e_index} !== {2'b01, 8'd0}) $display("FAIL empty_status: got busy/cap/index %b expected %b", {e_busy, e_capture_en, e_index}, {2'b01, 8'd0});
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    prev_sioc = 1'b1;
    prev_line = 1'b1;
    e_prev_sioc = 1'b1;
    in_tx = 1'b0;
    nbits = 0;
    shreg = '0;
    tb_table[0] = 16'h1204;
    tb_table[1] = 16'h40D0;
    clear_mon();
    test_reset();
    test_auto_run();
    test_start_while_busy();
    test_restart();
    test_reset_mid_run();
    test_empty_table();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
